// File: rtl/ube_pkg.sv
// Shared types and constants for the KS-10 UBE DMA sequencer.
package ube_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_STEP,
    ST_FIN
  } ube_state_e;

  localparam int unsigned UBE_TIMEOUT_DEF = 64;

  // Word count byte-lane merge, matching the ubeBA_HI/LO accessor style.
  function automatic logic [15:0] ubeWC_WR(input logic [15:0] cur,
                                           input logic [15:0] data,
                                           input logic        hi,
                                           input logic        lo);
    logic [15:0] res;
    res       = cur;
    if (hi) res[15:8] = data[15:8];
    if (lo) res[7:0]  = data[7:0];
    return res;
  endfunction

endpackage

// File: rtl/ube_timeout.sv
// Loadable up-counter with a terminal-count flag, used for the DMA ack timeout.
module ube_timeout #(
  parameter int unsigned TC = 63,
  parameter int unsigned W  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_en)   r_cnt <= r_cnt + W'(1);
  end

  assign o_tc = (r_cnt == W'(TC));

endmodule

// File: rtl/ube_dma_seq.sv
// UBE DMA sequencer: word count register plus the transfer FSM that
// issues Unibus DMA requests and reports busy/done/NXM to the CSR.
module ube_dma_seq
  import ube_pkg::*;
#(
  parameter int unsigned TIMEOUT = UBE_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        devRESET,
  input  logic        devHIBYTE,
  input  logic        devLOBYTE,
  input  logic [35:0] devDATAI,
  input  logic        wcWRITE,
  input  logic        dmaGO,
  input  logic        dmaWRITE,
  input  logic [15:0] regBA,
  output logic        ubeINC,
  output logic [15:0] regWC,
  output logic        dmaREQ,
  output logic        dmaDIR,
  output logic [15:0] dmaADDR,
  input  logic        dmaACK,
  output logic        busy,
  output logic        done,
  output logic        nxm,
  output logic        intr
);

  ube_state_e  r_state;
  logic [15:0] r_wc;
  logic        r_req, r_dir, r_inc, r_busy, r_done, r_nxm, r_intr;
  logic [15:0] w_wc_inc;
  logic        w_tc;
  logic        w_unused;

  assign w_wc_inc = r_wc + 16'd1;
  assign w_unused = ^devDATAI[35:16];

  // Counter is held at zero outside XFER, so every XFER entry starts fresh.
  ube_timeout #(
    .TC (TIMEOUT - 1),
    .W  (8)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst),
    .i_load (devRESET || (r_state != ST_XFER)),
    .i_val  ('0),
    .i_en   (1'b1),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_wc    <= '0;
      r_req   <= 1'b0;
      r_dir   <= 1'b0;
      r_inc   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_nxm   <= 1'b0;
      r_intr  <= 1'b0;
    end else if (devRESET) begin
      r_state <= ST_IDLE;
      r_wc    <= '0;
      r_req   <= 1'b0;
      r_dir   <= 1'b0;
      r_inc   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_nxm   <= 1'b0;
      r_intr  <= 1'b0;
    end else begin
      r_inc  <= 1'b0;
      r_intr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (wcWRITE) r_wc <= ubeWC_WR(r_wc, devDATAI[15:0], devHIBYTE, devLOBYTE);
          if (dmaGO) begin
            r_done <= 1'b0;
            r_nxm  <= 1'b0;
            r_dir  <= dmaWRITE;
            r_busy <= 1'b1;
            if (r_wc == '0) begin
              r_state <= ST_FIN;
              r_intr  <= 1'b1;
            end else begin
              r_state <= ST_XFER;
              r_req   <= 1'b1;
            end
          end
        end
        ST_XFER: begin
          if (dmaACK) begin
            r_state <= ST_STEP;
            r_req   <= 1'b0;
            r_inc   <= 1'b1;
          end else if (w_tc) begin
            r_state <= ST_FIN;
            r_req   <= 1'b0;
            r_nxm   <= 1'b1;
            r_intr  <= 1'b1;
          end
        end
        ST_STEP: begin
          r_wc <= w_wc_inc;
          if (w_wc_inc == '0) begin
            r_state <= ST_FIN;
            r_intr  <= 1'b1;
          end else begin
            r_state <= ST_XFER;
            r_req   <= 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= !r_nxm;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ubeINC  = r_inc;
  assign regWC   = r_wc;
  assign dmaREQ  = r_req;
  assign dmaDIR  = r_dir;
  assign dmaADDR = r_req ? regBA : '0;
  assign busy    = r_busy;
  assign done    = r_done;
  assign nxm     = r_nxm;
  assign intr    = r_intr;

endmodule

// File: tb/tb_ube_dma_seq.sv
// Self-checking bench for ube_dma_seq with a transfer-level reference model.
module tb_ube_dma_seq;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        devRESET = 1'b0, devHIBYTE = 1'b0, devLOBYTE = 1'b0;
  logic [35:0] devDATAI = '0;
  logic        wcWRITE = 1'b0, dmaGO = 1'b0, dmaWRITE = 1'b0, dmaACK = 1'b0;
  logic [15:0] regBA = '0;
  logic        ubeINC, dmaREQ, dmaDIR, busy, done, nxm, intr;
  logic [15:0] regWC, dmaADDR;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ube_dma_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .devRESET(devRESET), .devHIBYTE(devHIBYTE),
    .devLOBYTE(devLOBYTE), .devDATAI(devDATAI), .wcWRITE(wcWRITE),
    .dmaGO(dmaGO), .dmaWRITE(dmaWRITE), .regBA(regBA), .ubeINC(ubeINC),
    .regWC(regWC), .dmaREQ(dmaREQ), .dmaDIR(dmaDIR), .dmaADDR(dmaADDR),
    .dmaACK(dmaACK), .busy(busy), .done(done), .nxm(nxm), .intr(intr)
  );

  // All tasks start and end positioned just after a falling edge.
  task automatic wc_write(input logic hi, input logic lo, input logic [35:0] d);
    wcWRITE = 1'b1; devHIBYTE = hi; devLOBYTE = lo; devDATAI = d;
    @(negedge clk);
    wcWRITE = 1'b0; devHIBYTE = 1'b0; devLOBYTE = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] outs;
    #12;
    outs = {ubeINC, regWC, dmaREQ, dmaDIR, dmaADDR, busy, done, nxm, intr};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_held got=%h exp=0", outs); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    outs = {ubeINC, regWC, dmaREQ, dmaDIR, dmaADDR, busy, done, nxm, intr};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_release got=%h exp=0", outs); end
  endtask

  task automatic test_lanes();
    logic [15:0] exp_wc;
    logic [35:0] d;
    logic        hi, lo;
    int          budget;
    wc_write(1'b1, 1'b0, 36'h0_0000_12AB);
    checks++;
    if (regWC !== 16'h1200) begin errors++; $display("FAIL lane_hi got=%h exp=1200", regWC); end
    wc_write(1'b0, 1'b1, 36'h0_0000_34CD);
    checks++;
    if (regWC !== 16'h12CD) begin errors++; $display("FAIL lane_lo got=%h exp=12CD", regWC); end
    exp_wc = 16'h12CD;
    for (int i = 0; i < 6; i++) begin
      d  = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
      hi = 1'($urandom_range(0, 1));
      lo = 1'($urandom_range(0, 1));
      wc_write(hi, lo, d);
      if (hi) exp_wc[15:8] = d[15:8];
      if (lo) exp_wc[7:0]  = d[7:0];
      checks++;
      if (regWC !== exp_wc) begin errors++; $display("FAIL lane_rand got=%h exp=%h", regWC, exp_wc); end
    end
    wc_write(1'b1, 1'b1, 36'h0_0000_FFFF);
    dmaGO = 1'b1; dmaWRITE = 1'b0;
    @(negedge clk);
    dmaGO = 1'b0;
    wc_write(1'b1, 1'b1, 36'h0_0000_5555);
    checks++;
    if (regWC !== 16'hFFFF) begin errors++; $display("FAIL wc_busy_write got=%h exp=FFFF", regWC); end
    dmaACK = 1'b1;
    @(negedge clk);
    dmaACK = 1'b0;
    budget = 20;
    while (busy && budget > 0) begin @(negedge clk); budget--; end
    checks++;
    if (busy || regWC !== 16'h0000 || done !== 1'b1) begin
      errors++; $display("FAIL busy_write_finish busy=%b wc=%h done=%b exp busy=0 wc=0000 done=1", busy, regWC, done);
    end
  endtask

  // Transfer-level model: n = 65536 - wc words, BA advances 4 per word,
  // each word costs (ack delay + 2) busy cycles, plus one FIN cycle.
  task automatic test_transfer(input logic [15:0] wc, input logic wr,
                               input int unsigned mind, input int unsigned maxd);
    int unsigned n, k, wait_c, d, incs, intrs, busyc, expc, budget;
    logic [15:0] ba0, exp_addr;
    n   = 32'h10000 - 32'(wc);
    ba0 = 16'($urandom) & 16'hFFFC;
    regBA = ba0;
    wc_write(1'b1, 1'b1, {20'h0, wc});
    checks++;
    if (regWC !== wc) begin errors++; $display("FAIL wc_load got=%h exp=%h", regWC, wc); end
    dmaGO = 1'b1; dmaWRITE = wr;
    @(negedge clk);
    dmaGO = 1'b0; dmaWRITE = ~wr;
    k = 0; wait_c = 0; incs = 0; intrs = 0; busyc = 0; expc = 1;
    d = $urandom_range(mind, maxd);
    budget = 2000;
    checks++;
    if (dmaREQ !== 1'b1) begin errors++; $display("FAIL go_latency req=%b exp=1", dmaREQ); end
    while (busy && budget > 0) begin
      busyc++;
      if (ubeINC) begin incs++; regBA = regBA + 16'd4; end
      if (intr) intrs++;
      if (dmaREQ) begin
        exp_addr = ba0 + 16'(4 * k);
        checks++;
        if (dmaADDR !== exp_addr) begin errors++; $display("FAIL dma_addr got=%h exp=%h", dmaADDR, exp_addr); end
        if (wait_c == d) begin
          dmaACK = 1'b1; expc += d + 2; k++; wait_c = 0;
          d = $urandom_range(mind, maxd);
        end else begin
          dmaACK = 1'b0; wait_c++;
        end
      end else begin
        dmaACK = 1'b0;
      end
      @(negedge clk);
      budget--;
    end
    dmaACK = 1'b0;
    checks++;
    if (budget == 0) begin errors++; $display("FAIL xfer_budget expired busy=%b exp=0", busy); end
    checks++;
    if (incs != n || k != n) begin errors++; $display("FAIL inc_count got=%0d acks=%0d exp=%0d", incs, k, n); end
    checks++;
    if (intrs != 1) begin errors++; $display("FAIL intr_count got=%0d exp=1", intrs); end
    checks++;
    if (busyc != expc) begin errors++; $display("FAIL busy_cycles got=%0d exp=%0d", busyc, expc); end
    checks++;
    if (done !== 1'b1 || nxm !== 1'b0 || regWC !== 16'h0000) begin
      errors++; $display("FAIL xfer_status done=%b nxm=%b wc=%h exp done=1 nxm=0 wc=0000", done, nxm, regWC);
    end
    checks++;
    if (dmaDIR !== wr) begin errors++; $display("FAIL dma_dir got=%b exp=%b", dmaDIR, wr); end
  endtask

  task automatic test_timeout();
    int unsigned reqc, incs, intrs, budget;
    wc_write(1'b1, 1'b1, 36'h0_0000_FFFF);
    dmaGO = 1'b1; dmaWRITE = 1'b1;
    @(negedge clk);
    dmaGO = 1'b0;
    reqc = 0; incs = 0; intrs = 0; budget = 300;
    while (busy && budget > 0) begin
      if (dmaREQ) reqc++;
      if (ubeINC) incs++;
      if (intr) intrs++;
      @(negedge clk);
      budget--;
    end
    checks++;
    if (budget == 0) begin errors++; $display("FAIL timeout_budget expired busy=%b exp=0", busy); end
    checks++;
    if (reqc != TO) begin errors++; $display("FAIL timeout_req_cycles got=%0d exp=%0d", reqc, TO); end
    checks++;
    if (nxm !== 1'b1 || done !== 1'b0 || regWC !== 16'hFFFF) begin
      errors++; $display("FAIL timeout_status nxm=%b done=%b wc=%h exp nxm=1 done=0 wc=FFFF", nxm, done, regWC);
    end
    checks++;
    if (incs != 0 || intrs != 1) begin errors++; $display("FAIL timeout_pulses inc=%0d intr=%0d exp inc=0 intr=1", incs, intrs); end
  endtask

  task automatic test_zero_count();
    wc_write(1'b1, 1'b1, 36'h0);
    dmaGO = 1'b1; dmaWRITE = 1'b0;
    @(negedge clk);
    dmaGO = 1'b0;
    checks++;
    if (intr !== 1'b1 || busy !== 1'b1 || dmaREQ !== 1'b0) begin
      errors++; $display("FAIL zero_fin intr=%b busy=%b req=%b exp intr=1 busy=1 req=0", intr, busy, dmaREQ);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || nxm !== 1'b0 || intr !== 1'b0 || dmaREQ !== 1'b0) begin
      errors++; $display("FAIL zero_done busy=%b done=%b nxm=%b intr=%b req=%b exp 0 1 0 0 0", busy, done, nxm, intr, dmaREQ);
    end
  endtask

  task automatic test_devreset();
    int unsigned incs, intrs, budget;
    wc_write(1'b1, 1'b1, 36'h0_0000_FFF0);
    dmaGO = 1'b1; dmaWRITE = 1'b1;
    @(negedge clk);
    dmaGO = 1'b0;
    incs = 0; intrs = 0; budget = 50;
    while (budget > 0) begin
      if (ubeINC) begin incs++; regBA = regBA + 16'd4; end
      if (intr) intrs++;
      if (dmaREQ && incs == 2) break;
      dmaACK = dmaREQ;
      @(negedge clk);
      budget--;
    end
    dmaACK = 1'b0;
    checks++;
    if (budget == 0) begin errors++; $display("FAIL devreset_budget incs=%0d exp=2", incs); end
    devRESET = 1'b1;
    @(negedge clk);
    devRESET = 1'b0;
    checks++;
    if (dmaREQ !== 1'b0 || busy !== 1'b0 || regWC !== 16'h0000 || done !== 1'b0 || nxm !== 1'b0 || dmaDIR !== 1'b0) begin
      errors++; $display("FAIL devreset_state req=%b busy=%b wc=%h done=%b nxm=%b dir=%b exp all 0",
                         dmaREQ, busy, regWC, done, nxm, dmaDIR);
    end
    for (int i = 0; i < 3; i++) begin
      if (intr) intrs++;
      @(negedge clk);
    end
    checks++;
    if (intrs != 0) begin errors++; $display("FAIL devreset_intr got=%0d exp=0", intrs); end
  endtask

  task automatic test_async_reset();
    logic [37:0] outs;
    regBA = 16'hBEEF;
    wc_write(1'b1, 1'b1, 36'h0_0000_FFFE);
    dmaGO = 1'b1; dmaWRITE = 1'b1;
    @(negedge clk);
    dmaGO = 1'b0;
    @(negedge clk);
    checks++;
    if (dmaREQ !== 1'b1) begin errors++; $display("FAIL async_pre req=%b exp=1", dmaREQ); end
    #2 rst = 1'b0;
    #1;
    outs = {ubeINC, regWC, dmaREQ, dmaDIR, dmaADDR, busy, done, nxm, intr};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL async_reset got=%h exp=0", outs); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dmaREQ !== 1'b0) begin errors++; $display("FAIL async_after busy=%b req=%b exp 0 0", busy, dmaREQ); end
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_transfer(16'hFFFD, 1'b1, 1, 1);
    for (int i = 0; i < 4; i++)
      test_transfer(16'hFFFF - 16'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 0, 3);
    test_timeout();
    test_zero_count();
    test_devreset();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ube_dma_seq.md
Name: ube_dma_seq

Overview:
Unibus Exerciser DMA sequencer for the KS-10 UBE. Holds the UBE word count register and runs the DMA transfer state machine. It drives Unibus DMA requests at the address held in the UBE buffer address register. After each acknowledged transfer it pulses ubeINC, which advances the buffer address by four. It also reports busy, done and non-existent-memory (NXM) status to the UBE CSR logic.

Parameters:
TIMEOUT, 64, cycles dmaREQ may stay unacknowledged before NXM is declared (range 2..255)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low
devRESET  input  1  device reset; synchronous, active-high
devHIBYTE  input  1  byte lane enable, bits 15:8
devLOBYTE  input  1  byte lane enable, bits 7:0
devDATAI  input  36  device write data; word count taken from bits 15:0
wcWRITE  input  1  word count register write strobe
dmaGO  input  1  start pulse from CSR
dmaWRITE  input  1  direction latched at GO; 1 = UBE-to-memory
regBA  input  16  current buffer address from the BA register
ubeINC  output  1  one-cycle pulse: advance BA by four
regWC  output  16  word count register, two's-complement negative count
dmaREQ  output  1  Unibus DMA request
dmaDIR  output  1  latched direction
dmaADDR  output  16  transfer address; equals regBA while dmaREQ=1
dmaACK  input  1  transfer complete from the bus side
busy  output  1  sequencer not idle
done  output  1  sticky completion flag
nxm  output  1  sticky timeout error flag
intr  output  1  one-cycle pulse on completion or error

Behaviour:
- Reset (rst low, async) and devRESET (sync) both do the same thing:
  - state := IDLE
  - regWC, done, nxm, dmaDIR, timeout counter := 0
  - all pulse outputs := 0
- Word count writes:
  - When wcWRITE=1 and state=IDLE, each enabled byte lane loads from devDATAI[15:8] / [7:0].
  - wcWRITE while busy is ignored.
- States: IDLE, XFER, STEP, FIN. Outputs are registered from the state.
- IDLE:
  - On dmaGO: clear done and nxm, latch dmaDIR := dmaWRITE.
  - If regWC==0: go to FIN. No transfer occurs.
  - Otherwise: go to XFER and clear the timeout counter.
  - dmaGO while not IDLE is ignored.
- XFER:
  - dmaREQ=1 and busy=1; the counter increments each cycle.
  - dmaACK=1: go to STEP. The ACK wins over a simultaneous timeout.
  - Counter reaches TIMEOUT-1 with no ACK: set nxm, go to FIN. regWC and BA are left unchanged.
- STEP (exactly one cycle):
  - ubeINC=1, regWC := regWC+1 (16-bit, wraps).
  - If the incremented value is 0, go to FIN.
  - Otherwise go to XFER with the counter cleared. dmaREQ is low for this one cycle, which gives the BA register time to update.
- FIN (one cycle): intr=1; done:=1 unless nxm is set; then IDLE.
- busy=1 in XFER, STEP and FIN.
- dmaACK outside XFER is ignored.
- Latency from GO to the first dmaREQ is 1 cycle. A transfer with ACK on its first XFER cycle costs 2 cycles per word.
- devRESET mid-transfer aborts immediately: dmaREQ drops on the next edge and intr does not pulse.
- regWC=0xFFFF gives exactly one transfer. regWC=0x0001 gives 65535 transfers.

Decomposition:
- Shared package ube_pkg:
  - state enum (IDLE, XFER, STEP, FIN)
  - word count byte-lane field macros, in the same style as the ubeBA_HI/LO accessors
  - the default timeout constant
- Natural sub-module: ube_timeout, a loadable up-counter with a terminal-count output. Everything else stays flat.

Test Plan:
1. Write WC=0xFFFD, GO, dmaWRITE=1, ACK one cycle after each REQ -> three ubeINC pulses, regWC ends at 0x0000, done=1, nxm=0, one intr pulse, dmaDIR=1.
2. WC=0, GO -> no dmaREQ, FIN reached on the 2nd cycle, done=1, one intr pulse.
3. WC=0xFFFF, GO, ACK never asserted, TIMEOUT=64 -> dmaREQ high for 64 cycles, then nxm=1, done=0, regWC remains 0xFFFF, no ubeINC.
4. WC=0xFFF0, GO, assert devRESET after 2 ACKs -> dmaREQ low next cycle, regWC=0, done/nxm=0, no intr.
5. Lane test: wcWRITE with HIBYTE only, devDATAI[15:0]=0x12AB -> regWC=0x1200; then LOBYTE only with 0x34CD -> regWC=0x12CD. A wcWRITE while busy leaves regWC unchanged.
6. Drop rst low asynchronously between clock edges during XFER -> all outputs 0 immediately, with no clock edge required.
